// File: rtl/ls595_deser.sv
// Serial-in, parallel-out word deserializer with a holding register, valid/read handshake
// and sticky overrun. MSB-first stream, word alignment from a frame pulse.
module ls595_deser #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             n_clr,
  input  logic             sin,
  input  logic             shift_en,
  input  logic             frame,
  input  logic             rd,
  input  logic             clr_ovr,
  output logic [WIDTH-1:0] q,
  output logic             valid,
  output logic             overrun,
  output logic [WIDTH-1:0] sr
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             complete;
  logic             ovr_set;
  logic [WIDTH-1:0] word;

  assign word = {sr_q[WIDTH-2:0], sin};

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    q_d      = q_q;
    valid_d  = valid_q;
    ovr_d    = ovr_q;
    complete = 1'b0;
    ovr_set  = 1'b0;

    if (shift_en) begin
      if (frame) begin
        // Frame always restarts alignment, even on what would be the completing bit.
        state_d = StShift;
        sr_d    = {{(WIDTH-1){1'b0}}, sin};
        cnt_d   = CntW'(1);
      end else if (state_q == StShift) begin
        sr_d = word;
        if (cnt_q == LastCnt) begin
          cnt_d    = '0;
          complete = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
    end

    if (complete) begin
      if (!valid_q || rd) begin
        q_d     = word;
        valid_d = 1'b1;
      end else begin
        ovr_set = 1'b1;
      end
    end else if (rd && valid_q) begin
      valid_d = 1'b0;
    end

    if (ovr_set) begin
      ovr_d = 1'b1;
    end else if (clr_ovr) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_clr) begin
    if (!n_clr) begin
      state_q <= StIdle;
      sr_q    <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign q       = q_q;
  assign valid   = valid_q;
  assign overrun = ovr_q;
  assign sr      = sr_q;

endmodule

// File: doc/ls595_deser.md
# ls595_deser

Serial-in, parallel-out word deserializer with a holding register and a valid/read handshake. It is the receive-side counterpart of the 74LS166-style parallel-to-serial pixel shifter. It reassembles an MSB-first serial bit stream, qualified by a per-bit enable, into WIDTH-bit words for downstream logic. Word alignment comes from a frame pulse; completed words sit in a holding register with sticky overrun detection, in the manner of a 74LS595 shift register plus storage latch.

## Interface
Parameters:
- WIDTH, 8, word width in bits; legal range 2..16.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- n_clr  in  1  reset, asynchronous, active-low.
- sin  in  1  serial data bit, sampled only when shift_en=1.
- shift_en  in  1  bit strobe; one bit is accepted per cycle with shift_en=1.
- frame  in  1  word-start marker, qualified by shift_en; marks the current sin as bit 0 (MSB) of a new word.
- rd  in  1  consumer read strobe; consumes the held word when valid=1.
- clr_ovr  in  1  synchronous clear of overrun.
- q  out  WIDTH  holding register (last completed word).
- valid  out  1  q holds an unread word.
- overrun  out  1  sticky: a completed word was dropped.
- sr  out  WIDTH  live shift register contents (debug/observation).

## Operation
- Shift register sr: on an accepted bit, sr <= {sr[WIDTH-2:0], sin}. The first bit received ends at sr[WIDTH-1], which matches the MSB-first order of the transmitter.
- Bit counter cnt, width clog2(WIDTH), counts accepted bits of the current word.
- State machine, two states:
  - IDLE (after reset): shift_en=1 with frame=0 is ignored (sr and cnt unchanged). shift_en=1 with frame=1 goes to SHIFT, loads sr with sin into the LSB, and sets cnt=1.
  - SHIFT: shift_en=1 with frame=0 shifts and increments cnt. When the accepted bit is bit WIDTH-1 (cnt==WIDTH-1), the word completes and cnt returns to 0, staying in SHIFT. Back-to-back words need no further frame. shift_en=1 with frame=1 discards the partial word, treats sin as bit 0, and sets cnt=1.
  - There is no return to IDLE except via reset.
- Word completion: the completed word is {sr[WIDTH-2:0], sin}.
  - If valid=0, or rd=1 in the same cycle: q <= word, valid <= 1.
  - Else (valid=1, rd=0): the word is dropped, q is unchanged, and overrun <= 1.
- rd with valid=1 and no completion: valid <= 0, q unchanged. rd with valid=0 is ignored.
- frame on the cycle that would complete a word: frame wins. No completion occurs, the WIDTH-1 partial bits are discarded, and cnt=1.
- overrun: set as above. clr_ovr=1 clears it. If set and clear happen in the same cycle, set wins.
- Async reset (n_clr=0), effective immediately regardless of clk: q=0, sr=0, valid=0, overrun=0, cnt=0, state=IDLE. A reset mid-word discards the partial word. After release, realignment requires a frame.

## Timing
- Every accepted bit appears in sr at the rising edge where shift_en=1 is sampled.
- Completion latency is zero extra cycles. q and valid update on the same edge that samples the WIDTH-th bit. The word is readable in the following cycle.
- Minimum word spacing is WIDTH cycles, with shift_en held high continuously.
- The handshake allows single-cycle consumption: rd=1 sampled with valid=1 clears valid on that edge. Asserting rd for one cycle per word at full rate sustains the stream with no overrun.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset: drive n_clr=0 mid-cycle with random inputs. q=0, sr=0, valid=0, overrun=0 immediately, with no clk edge needed. Bits sent after release without frame leave sr=0.
- Single word: frame+shift_en on the first bit, then shift in 0xA5 MSB-first (1,0,1,0,0,1,0,1). q=0xA5 and valid=1 on the 8th bit's edge. rd for one cycle gives valid=0.
- Back-to-back: 16 continuous bits 0x3C then 0xC3, one frame only, rd pulsed the cycle after each valid. Receives 0x3C then 0xC3, overrun=0.
- Overrun: two words 0x11, 0x22 with no rd. q stays 0x11, valid=1, overrun=1. clr_ovr gives overrun=0. Also check clr_ovr asserted on the completing edge of a third dropped word leaves overrun=1.
- Realignment: 5 bits, then frame starts 0x5A. q=0x5A with no word from the partial bits. Also check frame exactly on the 8th bit: no completion, and the next 7 bits plus that bit form the word.
- Simultaneous rd and completion with valid=1: holding 0x77, rd on the final bit of 0x88 gives q=0x88, valid=1, overrun=0.
